// File: rtl/dspm_load_merger_pkg.sv
// Shared types for the D-cache SPM load merger: requester/controller port
// structs, the merger FSM state encoding and a merged-read builder.
package dspm_load_merger_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_TAG = 2'd1,
    ISSUE    = 2'd2,
    DRAIN    = 2'd3
  } dspm_merge_state_e;

  // A single-cycle read towards the controller: index and tag together, no write data.
  function automatic dcache_req_i_t merged_read(
    input logic [DCACHE_INDEX_WIDTH-1:0] index,
    input logic [DCACHE_TAG_WIDTH-1:0]   tag,
    input logic [7:0]                    be,
    input logic [1:0]                    size
  );
    dcache_req_i_t r;
    r               = '0;
    r.data_req      = 1'b1;
    r.address_index = index;
    r.address_tag   = tag;
    r.data_be       = be;
    r.data_size     = size;
    return r;
  endfunction

endpackage

// File: rtl/dspm_load_merger.sv
// Joins the split-phase (index, then tag) load request into one held request
// for the SPM controller. Optional macro: DSPM_MERGE_FAST_ISSUE_EN.
module dspm_load_merger
  import dspm_load_merger_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t req_port_i,
  output dcache_req_o_t req_port_o,
  output dcache_req_i_t spm_req_o,
  input  dcache_req_o_t spm_req_i,
  output logic          busy_o
);

  dspm_merge_state_e               state_q, state_d;
  logic [DCACHE_INDEX_WIDTH-1:0]   index_q, index_d;
  logic [DCACHE_TAG_WIDTH-1:0]     tag_q, tag_d;
  logic [7:0]                      be_q, be_d;
  logic [1:0]                      size_q, size_d;
  logic                            killed_q, killed_d;
  logic                            stray_rvalid;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tag_d      = tag_q;
    be_d       = be_q;
    size_d     = size_q;
    killed_d   = killed_q;
    spm_req_o  = '0;
    req_port_o = '0;

    unique case (state_q)
      IDLE: begin
        if (req_port_i.data_req && req_port_i.data_we) begin
          spm_req_o           = req_port_i;
          spm_req_o.tag_valid = 1'b0;
          spm_req_o.kill_req  = 1'b0;
          req_port_o.data_gnt = spm_req_i.data_gnt;
        end else if (req_port_i.data_req) begin
          req_port_o.data_gnt = 1'b1;
          index_d             = req_port_i.address_index;
          be_d                = req_port_i.data_be;
          size_d              = req_port_i.data_size;
          state_d             = WAIT_TAG;
        end
      end

      WAIT_TAG: begin
        if (req_port_i.kill_req) begin
          state_d = IDLE;
        end else if (req_port_i.tag_valid) begin
          tag_d   = req_port_i.address_tag;
          state_d = ISSUE;
`ifdef DSPM_MERGE_FAST_ISSUE_EN
          // Live tag goes straight out; an immediate response closes the read here.
          spm_req_o = merged_read(index_q, req_port_i.address_tag, be_q, size_q);
          if (spm_req_i.data_rvalid) begin
            req_port_o.data_rvalid = 1'b1;
            req_port_o.data_rdata  = spm_req_i.data_rdata;
            state_d                = IDLE;
          end
`endif
        end
      end

      ISSUE: begin
        spm_req_o = merged_read(index_q, tag_q, be_q, size_q);
        if (req_port_i.kill_req) begin
          // The controller may already own this request, so keep it up and drop the answer.
          killed_d = 1'b1;
          state_d  = DRAIN;
          if (spm_req_i.data_rvalid) begin
            killed_d = 1'b0;
            state_d  = IDLE;
          end
        end else if (spm_req_i.data_rvalid) begin
          if (!killed_q) begin
            req_port_o.data_rvalid = 1'b1;
            req_port_o.data_rdata  = spm_req_i.data_rdata;
          end
          killed_d = 1'b0;
          state_d  = IDLE;
        end
      end

      DRAIN: begin
        spm_req_o = merged_read(index_q, tag_q, be_q, size_q);
        if (spm_req_i.data_rvalid) begin
          killed_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      index_q  <= '0;
      tag_q    <= '0;
      be_q     <= '0;
      size_q   <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      tag_q    <= tag_d;
      be_q     <= be_d;
      size_q   <= size_d;
      killed_q <= killed_d;
    end
  end

  assign busy_o = (state_q != IDLE);

`ifdef DSPM_MERGE_FAST_ISSUE_EN
  assign stray_rvalid = spm_req_i.data_rvalid &&
                        ((state_q == IDLE) ||
                         ((state_q == WAIT_TAG) &&
                          !(req_port_i.tag_valid && !req_port_i.kill_req)));
`else
  assign stray_rvalid = spm_req_i.data_rvalid &&
                        ((state_q == IDLE) || (state_q == WAIT_TAG));
`endif

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) !stray_rvalid)
    else $error("dspm_load_merger: controller rvalid with no read outstanding");

endmodule

// File: tb/tb_dspm_load_merger.sv
// Self-checking bench for dspm_load_merger: directed vector table, hand-written
// kill/back-pressure/reset sequences, and randomized traffic against a transaction model.
module tb_dspm_load_merger;
  import dspm_load_merger_pkg::*;

  logic          clk;
  logic          rst_n;
  dcache_req_i_t req_i;
  dcache_req_o_t req_o;
  dcache_req_i_t spm_o;
  dcache_req_o_t spm_i;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  dspm_load_merger dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_port_i (req_i),
    .req_port_o (req_o),
    .spm_req_o  (spm_o),
    .spm_req_i  (spm_i),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        req, we, tv, kill;
    logic [11:0] idx;
    logic [43:0] tag;
    logic [7:0]  be;
    logic [63:0] wd;
    logic        sgnt, srv;
    logic [63:0] srd;
    logic        e_gnt, e_rv;
    logic [63:0] e_rd;
    logic        e_sreq, e_swe;
    logic [11:0] e_sidx;
    logic [43:0] e_stag;
    logic        e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(
    input string nm, input logic req, input logic we, input logic tv, input logic kill,
    input logic [11:0] idx, input logic [43:0] tag, input logic [7:0] be, input logic [63:0] wd,
    input logic sgnt, input logic srv, input logic [63:0] srd,
    input logic e_gnt, input logic e_rv, input logic [63:0] e_rd,
    input logic e_sreq, input logic e_swe, input logic [11:0] e_sidx, input logic [43:0] e_stag,
    input logic e_busy);
    vec_t v;
    v.name = nm; v.req = req; v.we = we; v.tv = tv; v.kill = kill;
    v.idx = idx; v.tag = tag; v.be = be; v.wd = wd;
    v.sgnt = sgnt; v.srv = srv; v.srd = srd;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_sreq = e_sreq; v.e_swe = e_swe; v.e_sidx = e_sidx; v.e_stag = e_stag;
    v.e_busy = e_busy;
    return v;
  endfunction

  function automatic dcache_req_i_t exp_read(input logic [11:0] idx, input logic [43:0] tag,
                                             input logic [7:0] be, input logic [1:0] size);
    dcache_req_i_t r;
    r = '0;
    r.data_req = 1'b1;
    r.address_index = idx;
    r.address_tag = tag;
    r.data_be = be;
    r.data_size = size;
    return r;
  endfunction

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input dcache_req_i_t act, input dcache_req_i_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_o(input string nm, input dcache_req_o_t act, input dcache_req_o_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic tv, input logic kill,
                       input logic [11:0] idx, input logic [43:0] tag, input logic [7:0] be,
                       input logic [63:0] wd, input logic sgnt, input logic srv,
                       input logic [63:0] srd);
    req_i = '0;
    req_i.data_req = req;
    req_i.data_we = we;
    req_i.tag_valid = tv;
    req_i.kill_req = kill;
    req_i.address_index = idx;
    req_i.address_tag = tag;
    req_i.data_be = be;
    req_i.data_size = 2'b11;
    req_i.data_wdata = wd;
    spm_i = '0;
    spm_i.data_gnt = sgnt;
    spm_i.data_rvalid = srv;
    spm_i.data_rdata = srd;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, '0, '0, '0, '0, 0, 0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: ph 0 = nothing pending, 1 = index accepted awaiting tag,
  // 2 = merged read outstanding at the controller (drop = requester no longer wants it).
  int          ph;
  bit          drop;
  logic [11:0] m_idx;
  logic [43:0] m_tag;
  logic [7:0]  m_be;
  logic [1:0]  m_size;

  initial begin
    dcache_req_i_t es;
    dcache_req_o_t eo;
    logic [63:0]   rd;

    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk64("reset_busy", 64'(busy), 64'd0);
    chk_s("reset_spm_req", spm_o, '0);
    chk_o("reset_req_port", req_o, '0);
    rst_n = 1'b1;
    step();

    // Directed vector table
    vt.push_back(mkv("rd_t0", 1,0,0,0, 'h0A8, 0, 'hFF, 0, 0,0,0,  1,0,0, 0,0,0,0, 0));
`ifdef DSPM_MERGE_FAST_ISSUE_EN
    vt.push_back(mkv("rd_t1", 0,0,1,0, 0, 'h3, 0, 0, 0,0,0,  0,0,0, 1,0,'h0A8,'h3, 1));
    vt.push_back(mkv("rd_t2", 0,0,0,0, 0, 0, 0, 0, 0,1,64'h1122334455667788,
                     0,1,64'h1122334455667788, 1,0,'h0A8,'h3, 1));
    vt.push_back(mkv("rd_t3", 0,0,0,0, 0, 0, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 0));
`else
    vt.push_back(mkv("rd_t1", 0,0,1,0, 0, 'h3, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 1));
    vt.push_back(mkv("rd_t2", 0,0,0,0, 0, 0, 0, 0, 0,0,0,  0,0,0, 1,0,'h0A8,'h3, 1));
    vt.push_back(mkv("rd_t3", 0,0,0,0, 0, 0, 0, 0, 0,1,64'h1122334455667788,
                     0,1,64'h1122334455667788, 1,0,'h0A8,'h3, 1));
    vt.push_back(mkv("rd_t4", 0,0,0,0, 0, 0, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 0));
`endif
    vt.push_back(mkv("st_gnt", 1,1,0,0, 'h010, 0, 'h0F, 64'hDEADBEEF, 1,0,0, 1,0,0, 1,1,'h010,0, 0));
    vt.push_back(mkv("st_after", 0,0,0,0, 0, 0, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 0));
    vt.push_back(mkv("st_nognt", 1,1,0,0, 'h020, 0, 'hF0, 64'h5A5A, 0,0,0, 0,0,0, 1,1,'h020,0, 0));
    vt.push_back(mkv("kw_t0", 1,0,0,0, 'h055, 0, 'hFF, 0, 0,0,0,  1,0,0, 0,0,0,0, 0));
    vt.push_back(mkv("kw_t1", 0,0,1,1, 0, 'h7, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 1));
    vt.push_back(mkv("kw_t2", 0,0,0,0, 0, 0, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 0));
    vt.push_back(mkv("kw_t3", 1,0,0,0, 'h066, 0, 'h01, 0, 0,0,0,  1,0,0, 0,0,0,0, 0));
    vt.push_back(mkv("kw_t4", 0,0,0,1, 0, 0, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 1));
    vt.push_back(mkv("kw_t5", 0,0,0,0, 0, 0, 0, 0, 0,0,0,  0,0,0, 0,0,0,0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].req, vt[i].we, vt[i].tv, vt[i].kill, vt[i].idx, vt[i].tag, vt[i].be,
            vt[i].wd, vt[i].sgnt, vt[i].srv, vt[i].srd);
      @(negedge clk);
      chk64({vt[i].name, "_gnt"}, 64'(req_o.data_gnt), 64'(vt[i].e_gnt));
      chk64({vt[i].name, "_rvalid"}, 64'(req_o.data_rvalid), 64'(vt[i].e_rv));
      if (vt[i].e_rv) chk64({vt[i].name, "_rdata"}, req_o.data_rdata, vt[i].e_rd);
      chk64({vt[i].name, "_spm_req"}, 64'(spm_o.data_req), 64'(vt[i].e_sreq));
      if (vt[i].e_sreq) begin
        chk64({vt[i].name, "_spm_we"}, 64'(spm_o.data_we), 64'(vt[i].e_swe));
        chk64({vt[i].name, "_spm_idx"}, 64'(spm_o.address_index), 64'(vt[i].e_sidx));
        chk64({vt[i].name, "_spm_tag"}, 64'(spm_o.address_tag), 64'(vt[i].e_stag));
      end
      chk64({vt[i].name, "_busy"}, 64'(busy), 64'(vt[i].e_busy));
      step();
    end

    // Kill while issued; controller answers 4 cycles late
    drive(1, 0, 0, 0, 'h1F0, 0, 'h0F, 0, 0, 0, 0);
    @(negedge clk);
    chk64("ki_gnt", 64'(req_o.data_gnt), 64'd1);
    step();
    drive(0, 0, 1, 0, 0, 'h2A, 0, 0, 0, 0, 0);
    step();
    es = exp_read('h1F0, 'h2A, 'h0F, 2'b11);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_s("ki_kill_cycle_req", spm_o, es);
    chk64("ki_kill_cycle_rvalid", 64'(req_o.data_rvalid), 64'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive(1, 1, 0, 0, 'h3FF, 'h1, 'hFF, 64'hBAD, 1, 0, 0);
      else        idle_in();
      @(negedge clk);
      chk_s("ki_hold_req", spm_o, es);
      chk64("ki_hold_rvalid", 64'(req_o.data_rvalid), 64'd0);
      chk64("ki_hold_gnt", 64'(req_o.data_gnt), 64'd0);
      chk64("ki_hold_busy", 64'(busy), 64'd1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hCA11AB1EBADCAB1E);
    @(negedge clk);
    chk_s("ki_rv_req", spm_o, es);
    chk64("ki_rv_suppressed", 64'(req_o.data_rvalid), 64'd0);
    step();
    idle_in();
    @(negedge clk);
    chk64("ki_idle_busy", 64'(busy), 64'd0);
    chk_s("ki_idle_req", spm_o, '0);
    step();

    // Back-pressure: second read while the first is outstanding
    drive(1, 0, 0, 0, 'h200, 0, 'hFF, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 0, 0, 'h11, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 'h300, 0, 'h3C, 0, 0, 0, 0);
      @(negedge clk);
      chk64("bp_wait_gnt", 64'(req_o.data_gnt), 64'd0);
      chk_s("bp_wait_req", spm_o, exp_read('h200, 'h11, 'hFF, 2'b11));
      step();
    end
    drive(1, 0, 0, 0, 'h300, 0, 'h3C, 0, 0, 1, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk64("bp_rv_gnt", 64'(req_o.data_gnt), 64'd0);
    chk64("bp_rv_rvalid", 64'(req_o.data_rvalid), 64'd1);
    chk64("bp_rv_rdata", req_o.data_rdata, 64'h0123456789ABCDEF);
    step();
    drive(1, 0, 0, 0, 'h300, 0, 'h3C, 0, 0, 0, 0);
    @(negedge clk);
    chk64("bp_second_gnt", 64'(req_o.data_gnt), 64'd1);
    step();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    idle_in();

    // Asynchronous reset while issued
    drive(1, 0, 0, 0, 'h0AB, 0, 'hFF, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 0, 0, 'h5, 0, 0, 0, 0, 0);
    step();
    idle_in();
    @(negedge clk);
    chk64("rst_pre_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk64("rst_async_busy", 64'(busy), 64'd0);
    chk_s("rst_async_req", spm_o, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk64("rst_after_busy", 64'(busy), 64'd0);
    step();

    // Randomized traffic against the transaction model
    ph = 0; drop = 0; m_idx = '0; m_tag = '0; m_be = '0; m_size = '0;
    for (int c = 0; c < 1500; c++) begin
      req_i.data_req      = ($urandom % 2) == 0;
      req_i.data_we       = ($urandom % 3) == 0;
      req_i.tag_valid     = ($urandom % 3) == 0;
      req_i.kill_req      = ($urandom % 8) == 0;
      req_i.address_index = 12'($urandom);
      req_i.address_tag   = {12'($urandom), 32'($urandom)};
      req_i.data_be       = 8'($urandom);
      req_i.data_size     = 2'($urandom);
      req_i.data_wdata    = {32'($urandom), 32'($urandom)};
      spm_i.data_gnt      = ($urandom % 2) == 0;
      spm_i.data_rvalid   = (ph == 2) && (($urandom % 4) == 0);
      spm_i.data_rdata    = {32'($urandom), 32'($urandom)};

      es = '0;
      eo = '0;
      @(negedge clk);
      chk64("rnd_busy", 64'(busy), 64'(ph != 0));
      if (ph == 0) begin
        if (req_i.data_req && req_i.data_we) begin
          es = req_i;
          es.tag_valid = 1'b0;
          es.kill_req = 1'b0;
          eo.data_gnt = spm_i.data_gnt;
        end else if (req_i.data_req) begin
          eo.data_gnt = 1'b1;
        end
      end else if (ph == 1) begin
`ifdef DSPM_MERGE_FAST_ISSUE_EN
        if (req_i.tag_valid && !req_i.kill_req)
          es = exp_read(m_idx, req_i.address_tag, m_be, m_size);
`endif
      end else begin
        es = exp_read(m_idx, m_tag, m_be, m_size);
        if (spm_i.data_rvalid && !drop && !req_i.kill_req) begin
          eo.data_rvalid = 1'b1;
          eo.data_rdata = spm_i.data_rdata;
        end
      end
      chk_s("rnd_spm_req", spm_o, es);
      chk_o("rnd_req_port", req_o, eo);

      if (ph == 0) begin
        if (req_i.data_req && !req_i.data_we) begin
          m_idx = req_i.address_index;
          m_be = req_i.data_be;
          m_size = req_i.data_size;
          ph = 1;
        end
      end else if (ph == 1) begin
        if (req_i.kill_req) ph = 0;
        else if (req_i.tag_valid) begin
          m_tag = req_i.address_tag;
          ph = 2;
        end
      end else begin
        if (spm_i.data_rvalid) begin
          ph = 0;
          drop = 0;
        end else if (req_i.kill_req) begin
          drop = 1;
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
